// File: rtl/uart_tx_fifo.sv
// UART transmitter with an input FIFO, so a producer can queue several words
// and get back-to-back frames. Word length, baud divisor, parity and stop bits are set at build time.
module uart_tx_fifo #(
    parameter int WORD_LENGHT  = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WORD_LENGHT-1:0]        Tx_in,
    input  logic                          send,
    output logic                          Tx_out,
    output logic                          Tx_ready,
    output logic                          Tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam int STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
    localparam int CW        = $clog2(STOP_CLKS + 1);
    localparam int BW        = $clog2(WORD_LENGHT);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic [WORD_LENGHT-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]          wrPtr_q;
    logic [AW-1:0]          rdPtr_q;
    logic [AW:0]            count_q;
    logic [AW:0]            count_d;
    logic                   ready_q;
    logic                   overflow_q;

    state_t                 state_q;
    logic [CW-1:0]          baud_q;
    logic [BW-1:0]          bit_q;
    logic [WORD_LENGHT-1:0] shift_q;
    logic                   parity_q;
    logic                   txOut_q;
    logic                   busy_q;

    logic                   pushEn;
    logic                   popEn;
    logic                   lastStop;
    logic                   lastBaud;
    logic [WORD_LENGHT-1:0] headWord;

    assign pushEn   = send && ready_q;
    assign lastBaud = (baud_q == CW'(CLKS_PER_BIT - 1));
    assign lastStop = (state_q == STOP) && (baud_q == CW'(STOP_CLKS - 1));
    assign popEn    = (count_q != '0) && ((state_q == IDLE) || lastStop);
    assign headWord = mem_q[rdPtr_q];

    always_comb begin
        count_d = count_q + {{AW{1'b0}}, pushEn} - {{AW{1'b0}}, popEn};
    end

    // Storage has no reset: pointers and count are what define the contents.
    always_ff @(posedge clk) begin
        if (pushEn) begin
            mem_q[wrPtr_q] <= Tx_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            ready_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (pushEn) begin
                wrPtr_q <= wrPtr_q + AW'(1);
            end
            if (popEn) begin
                rdPtr_q <= rdPtr_q + AW'(1);
            end
            count_q    <= count_d;
            ready_q    <= (count_d != (AW + 1)'(FIFO_DEPTH));
            overflow_q <= send && !ready_q;
        end
    end

    // Popping at the last stop cycle jumps straight to START, giving zero idle gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            txOut_q  <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    txOut_q <= 1'b1;
                    if (popEn) begin
                        shift_q  <= headWord;
                        parity_q <= (PARITY_MODE == 2) ? ~(^headWord) : ^headWord;
                        baud_q   <= '0;
                        txOut_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= START;
                    end
                end
                START: begin
                    if (lastBaud) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        txOut_q <= shift_q[0];
                        state_q <= DATA;
                    end else begin
                        baud_q <= baud_q + CW'(1);
                    end
                end
                DATA: begin
                    if (lastBaud) begin
                        baud_q <= '0;
                        if (bit_q == BW'(WORD_LENGHT - 1)) begin
                            if (PARITY_MODE != 0) begin
                                txOut_q <= parity_q;
                                state_q <= PARITY;
                            end else begin
                                txOut_q <= 1'b1;
                                state_q <= STOP;
                            end
                        end else begin
                            bit_q   <= bit_q + BW'(1);
                            shift_q <= shift_q >> 1;
                            txOut_q <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + CW'(1);
                    end
                end
                PARITY: begin
                    if (lastBaud) begin
                        baud_q  <= '0;
                        txOut_q <= 1'b1;
                        state_q <= STOP;
                    end else begin
                        baud_q <= baud_q + CW'(1);
                    end
                end
                STOP: begin
                    if (lastStop) begin
                        baud_q <= '0;
                        if (popEn) begin
                            shift_q  <= headWord;
                            parity_q <= (PARITY_MODE == 2) ? ~(^headWord) : ^headWord;
                            txOut_q  <= 1'b0;
                            state_q  <= START;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + CW'(1);
                    end
                end
                default: begin
                    txOut_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Tx_out     = txOut_q;
    assign Tx_ready   = ready_q;
    assign Tx_busy    = busy_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: default build plus even-parity/2-stop and odd-parity builds.
module tb_uart_tx_fifo;

    logic       clk;
    logic       rst;
    logic [7:0] txIn;
    logic       send;
    logic       sendB;
    logic       sendC;

    logic       txOutA, readyA, busyA, overflowA;
    logic [2:0] countA;
    logic       txOutB, readyB, busyB, overflowB;
    logic [2:0] countB;
    logic       txOutC, readyC, busyC, overflowC;
    logic [2:0] countC;

    int testsRun    = 0;
    int testsFailed = 0;

    uart_tx_fifo dutA (
        .clk(clk), .rst(rst), .Tx_in(txIn), .send(send),
        .Tx_out(txOutA), .Tx_ready(readyA), .Tx_busy(busyA),
        .fifo_count(countA), .overflow(overflowA)
    );

    uart_tx_fifo #(.PARITY_MODE(1), .STOP_BITS(2)) dutB (
        .clk(clk), .rst(rst), .Tx_in(txIn), .send(sendB),
        .Tx_out(txOutB), .Tx_ready(readyB), .Tx_busy(busyB),
        .fifo_count(countB), .overflow(overflowB)
    );

    uart_tx_fifo #(.PARITY_MODE(2)) dutC (
        .clk(clk), .rst(rst), .Tx_in(txIn), .send(sendC),
        .Tx_out(txOutC), .Tx_ready(readyC), .Tx_busy(busyC),
        .fifo_count(countC), .overflow(overflowC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] word);
        txIn = word;
        send = 1'b1;
        tick();
    endtask

    task automatic checkBit(input string tag, input logic observed, input logic expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Walks one frame from its first start cycle (minus 'skip' already-elapsed cycles),
    // optionally pushing a word on A during the final stop cycle.
    task automatic expectFrame(input int which, input string tag, input logic [7:0] word,
                               input int parityMode, input int stopBits, input int skip,
                               input logic pushLast, input logic [7:0] pushWord);
        logic expBits [12];
        int   nBits;
        logic par;
        logic obs;
        logic busyObs;
        par   = (parityMode == 2) ? ~(^word) : ^word;
        nBits = 0;
        expBits[nBits] = 1'b0;
        nBits++;
        for (int i = 0; i < 8; i++) begin
            expBits[nBits] = word[i];
            nBits++;
        end
        if (parityMode != 0) begin
            expBits[nBits] = par;
            nBits++;
        end
        for (int i = 0; i < stopBits; i++) begin
            expBits[nBits] = 1'b1;
            nBits++;
        end
        for (int cyc = skip; cyc < nBits * 4; cyc++) begin
            obs     = (which == 0) ? txOutA : (which == 1) ? txOutB : txOutC;
            busyObs = (which == 0) ? busyA  : (which == 1) ? busyB  : busyC;
            checkBit($sformatf("%s.bit%0d.c%0d", tag, cyc / 4, cyc % 4), obs, expBits[cyc / 4]);
            if (cyc % 4 == 0) begin
                checkBit($sformatf("%s.busy%0d", tag, cyc / 4), busyObs, 1'b1);
            end
            if (pushLast && cyc == nBits * 4 - 1) begin
                txIn = pushWord;
                send = 1'b1;
            end
            tick();
        end
        send = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        send  = 1'b0;
        sendB = 1'b0;
        sendC = 1'b0;
        txIn  = 8'h00;
        tick();
        tick();
        checkBit("rst.txOut", txOutA, 1'b1);
        checkBit("rst.ready", readyA, 1'b1);
        checkBit("rst.busy", busyA, 1'b0);
        checkOutput("rst.count", 32'(countA), 32'd0);
        checkBit("rst.overflow", overflowA, 1'b0);
        checkBit("rst.txOutB", txOutB, 1'b1);
        rst = 1'b0;

        // Single 0x55 frame, 40 cycles
        applyStimulus(8'h55);
        send = 1'b0;
        txIn = 8'h00;
        checkOutput("f55.countPush", 32'(countA), 32'd1);
        checkBit("f55.busyBefore", busyA, 1'b0);
        checkBit("f55.idleLine", txOutA, 1'b1);
        tick();
        checkOutput("f55.countPop", 32'(countA), 32'd0);
        expectFrame(0, "f55", 8'h55, 0, 1, 0, 1'b0, 8'h00);
        checkBit("f55.busyAfter", busyA, 1'b0);
        checkBit("f55.lineAfter", txOutA, 1'b1);

        // Even parity with two stop bits, then odd parity
        txIn  = 8'h01;
        sendB = 1'b1;
        tick();
        sendB = 1'b0;
        tick();
        expectFrame(1, "parEven", 8'h01, 1, 2, 0, 1'b0, 8'h00);
        checkBit("parEven.busyAfter", busyB, 1'b0);
        sendC = 1'b1;
        tick();
        sendC = 1'b0;
        tick();
        expectFrame(2, "parOdd", 8'h01, 2, 1, 0, 1'b0, 8'h00);
        checkBit("parOdd.busyAfter", busyC, 1'b0);

        // Back-to-back frames
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        checkOutput("b2b.countAfterPop", 32'(countA), 32'd1);
        checkBit("b2b.startLow", txOutA, 1'b0);
        applyStimulus(8'h33);
        send = 1'b0;
        txIn = 8'hFF;
        checkOutput("b2b.countPeak", 32'(countA), 32'd2);
        checkBit("b2b.ready", readyA, 1'b1);
        expectFrame(0, "b2b11", 8'h11, 0, 1, 1, 1'b0, 8'h00);
        checkOutput("b2b.count1", 32'(countA), 32'd1);
        expectFrame(0, "b2b22", 8'h22, 0, 1, 0, 1'b0, 8'h00);
        checkOutput("b2b.count0", 32'(countA), 32'd0);
        expectFrame(0, "b2b33", 8'h33, 0, 1, 0, 1'b0, 8'h00);
        checkBit("b2b.busyAfter", busyA, 1'b0);

        // Push and pop at the same edge with two words queued
        applyStimulus(8'h41);
        applyStimulus(8'h42);
        applyStimulus(8'h43);
        send = 1'b0;
        checkOutput("pp.countBefore", 32'(countA), 32'd2);
        expectFrame(0, "pp41", 8'h41, 0, 1, 1, 1'b1, 8'h44);
        checkOutput("pp.countSame", 32'(countA), 32'd2);
        expectFrame(0, "pp42", 8'h42, 0, 1, 0, 1'b0, 8'h00);
        expectFrame(0, "pp43", 8'h43, 0, 1, 0, 1'b0, 8'h00);
        expectFrame(0, "pp44", 8'h44, 0, 1, 0, 1'b0, 8'h00);
        checkBit("pp.busyAfter", busyA, 1'b0);
        checkOutput("pp.countAfter", 32'(countA), 32'd0);

        // Overflow: six pushes, the sixth is dropped
        applyStimulus(8'hA1);
        applyStimulus(8'hB2);
        applyStimulus(8'hC3);
        applyStimulus(8'hD4);
        checkOutput("ovf.count3", 32'(countA), 32'd3);
        checkBit("ovf.readyHigh", readyA, 1'b1);
        applyStimulus(8'hE5);
        checkOutput("ovf.count4", 32'(countA), 32'd4);
        checkBit("ovf.readyLow", readyA, 1'b0);
        checkBit("ovf.noPulseYet", overflowA, 1'b0);
        applyStimulus(8'hF6);
        send = 1'b0;
        checkBit("ovf.pulse", overflowA, 1'b1);
        checkOutput("ovf.countHeld", 32'(countA), 32'd4);
        tick();
        checkBit("ovf.pulseEnd", overflowA, 1'b0);
        expectFrame(0, "ovfA1", 8'hA1, 0, 1, 5, 1'b0, 8'h00);
        checkOutput("ovf.countAfterA1", 32'(countA), 32'd3);
        checkBit("ovf.readyAgain", readyA, 1'b1);
        expectFrame(0, "ovfB2", 8'hB2, 0, 1, 0, 1'b0, 8'h00);
        expectFrame(0, "ovfC3", 8'hC3, 0, 1, 0, 1'b0, 8'h00);
        expectFrame(0, "ovfD4", 8'hD4, 0, 1, 0, 1'b0, 8'h00);
        expectFrame(0, "ovfE5", 8'hE5, 0, 1, 0, 1'b0, 8'h00);
        checkBit("ovf.busyAfter", busyA, 1'b0);
        checkOutput("ovf.countAfter", 32'(countA), 32'd0);
        repeat (10) tick();
        checkBit("ovf.noSixth", txOutA, 1'b1);
        checkBit("ovf.stillIdle", busyA, 1'b0);

        // Reset during data bit 3 of 0xA5 with two words queued
        applyStimulus(8'hA5);
        applyStimulus(8'h5A);
        applyStimulus(8'h3C);
        send = 1'b0;
        repeat (16) tick();
        checkBit("rstMid.bit3", txOutA, 1'b0);
        checkOutput("rstMid.countBefore", 32'(countA), 32'd2);
        checkBit("rstMid.busyBefore", busyA, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkBit("rstMid.txOut", txOutA, 1'b1);
        checkOutput("rstMid.count", 32'(countA), 32'd0);
        checkBit("rstMid.busy", busyA, 1'b0);
        checkBit("rstMid.ready", readyA, 1'b1);
        for (int i = 0; i < 6; i++) begin
            repeat (10) tick();
            checkBit($sformatf("rstMid.quietLine%0d", i), txOutA, 1'b1);
            checkBit($sformatf("rstMid.quietBusy%0d", i), busyA, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
